i2s_tx_slot: RTL and testbench

- Parametrised I2S/left-justified transmitter; successor to the fixed 16-bit transmitter.
- Serialises stereo PCM pairs onto ws_o/sdata_o, one bit per sclk_i.
- Configurable sample width, slot width and framing mode.
- Input side is a ready/valid sample stream with a one-entry holding buffer, underrun detection and mute.
- Sits between the audio DSP output stream and the codec pins.

---
 rtl/i2s_pkg.sv | 16 +
 rtl/i2s_frame_buf.sv | 48 ++++
 rtl/i2s_tx_slot.sv | 135 +++++++++++++
 tb/tb_i2s_tx_slot.sv | 188 ++++++++++++++++++
 4 files changed

// File: rtl/i2s_pkg.sv
// i2s_pkg: shared types and helpers for the slot-configurable I2S transmitter.
//   i2s_mode_e - framing: I2S_PHILIPS (data lags ws by one sclk) or I2S_LJ.
//   i2s_cnt_w  - width of the frame bit counter for a given slot width.
package i2s_pkg;

  typedef enum logic {
    I2S_PHILIPS = 1'b0,
    I2S_LJ      = 1'b1
  } i2s_mode_e;

  // Counter spans both slots: 0 .. 2*slot_w-1.
  function automatic int i2s_cnt_w(input int slot_w);
    return $clog2(2 * slot_w);
  endfunction

endpackage

// File: rtl/i2s_frame_buf.sv
// i2s_frame_buf: one-entry holding register between the sample stream and
// the serialiser.
//   clk_i  - bit clock, state updates on the falling edge
//   rst_i  - synchronous active-high reset, empties the entry
//   push_i - write data_i (accepted handshake)
//   pop_i  - frame load takes the entry; push_i on the same edge refills it
//   full_o - entry holds an unread pair
//   data_o - held pair
module i2s_frame_buf #(
  parameter int WIDTH = 32
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             push_i,
  input  logic             pop_i,
  input  logic [WIDTH-1:0] data_i,
  output logic             full_o,
  output logic [WIDTH-1:0] data_o
);

  logic             full_q, full_d;
  logic [WIDTH-1:0] data_q, data_d;

  always_comb begin
    full_d = full_q;
    data_d = data_q;
    if (pop_i) full_d = 1'b0;
    // Push wins over pop so a pair written on the load edge stays buffered.
    if (push_i) begin
      full_d = 1'b1;
      data_d = data_i;
    end
  end

  always_ff @(negedge clk_i) begin
    if (rst_i) begin
      full_q <= 1'b0;
      data_q <= '0;
    end else begin
      full_q <= full_d;
      data_q <= data_d;
    end
  end

  assign full_o = full_q;
  assign data_o = data_q;

endmodule

// File: rtl/i2s_tx_slot.sv
// i2s_tx_slot: I2S / left-justified stereo transmitter with configurable
// sample and slot widths, ready/valid input, underrun flag and mute.
//   sclk_i      - bit clock; all state changes on its falling edge
//   rst_i       - synchronous active-high reset
//   left_i/right_i, valid_i, ready_o - sample pair stream
//   mute_i      - frame loaded as zeros (stream still consumed)
//   ws_o        - word select, 0 = left slot, 1 = right slot
//   sdata_o     - serial data, MSB first, padding bits are 0
//   underrun_o  - one-cycle pulse when a frame load finds the buffer empty
module i2s_tx_slot
  import i2s_pkg::*;
#(
  parameter int        DATA_W          = 16,
  parameter int        SLOT_W          = 16,
  parameter i2s_mode_e MODE            = I2S_PHILIPS,
  parameter bit        UNDERRUN_REPEAT = 1'b0
) (
  input  logic              sclk_i,
  input  logic              rst_i,
  input  logic [DATA_W-1:0] left_i,
  input  logic [DATA_W-1:0] right_i,
  input  logic              valid_i,
  output logic              ready_o,
  input  logic              mute_i,
  output logic              ws_o,
  output logic              sdata_o,
  output logic              underrun_o
);

  localparam int                 CNT_W    = i2s_cnt_w(SLOT_W);
  localparam logic [CNT_W-1:0]   LAST_CNT = CNT_W'(2 * SLOT_W - 1);
  localparam logic [CNT_W-1:0]   SLOT_CNT = CNT_W'(SLOT_W);

  typedef struct packed {
    logic [DATA_W-1:0] left;
    logic [DATA_W-1:0] right;
  } frame_t;

  // Bit transmitted at frame position pos of frame f (left-justified in slot).
  function automatic logic slot_bit(input frame_t f, input logic [CNT_W-1:0] pos);
    logic [DATA_W-1:0] s;
    logic [CNT_W-1:0]  i;
    logic              b;
    if (pos < SLOT_CNT) begin
      s = f.left;
      i = pos;
    end else begin
      s = f.right;
      i = pos - SLOT_CNT;
    end
    b = 1'b0;
    if (int'(i) < DATA_W) begin
      s = s << i;
      b = s[DATA_W-1];
    end
    return b;
  endfunction

  logic [CNT_W-1:0] cnt_q, cnt_d;
  frame_t           frame_q, frame_d;   // active frame being shifted out
  frame_t           last_q, last_d;     // last unmuted pair taken from buffer
  logic             ws_q, ws_d;
  logic             sdata_q, sdata_d;
  logic             ur_q, ur_d;

  logic             load_cycle;
  logic             push;
  logic             buf_full;
  frame_t           in_frame;
  frame_t           buf_frame;
  frame_t           nxt_frame;

  assign load_cycle = (cnt_q == LAST_CNT);
  assign ready_o    = !rst_i && (!buf_full || load_cycle);
  assign push       = valid_i && ready_o;
  assign in_frame   = '{left: left_i, right: right_i};

  i2s_frame_buf #(
    .WIDTH ($bits(frame_t))
  ) u_buf (
    .clk_i  (sclk_i),
    .rst_i  (rst_i),
    .push_i (push),
    .pop_i  (load_cycle),
    .data_i (in_frame),
    .full_o (buf_full),
    .data_o (buf_frame)
  );

  always_comb begin
    cnt_d     = load_cycle ? '0 : cnt_q + CNT_W'(1);
    frame_d   = frame_q;
    last_d    = last_q;
    ur_d      = 1'b0;
    nxt_frame = '0;
    if (load_cycle) begin
      ur_d = !buf_full;
      if (buf_full) begin
        nxt_frame = buf_frame;
        last_d    = buf_frame;
      end else if (UNDERRUN_REPEAT) begin
        nxt_frame = last_q;
      end
      frame_d = mute_i ? '0 : nxt_frame;
    end
    ws_d = (cnt_d >= SLOT_CNT);
    // Philips lags by one bit: the position one behind cnt_d is cnt_q, still
    // read from the old frame, so the previous right LSB lands on count 0.
    if (MODE == I2S_LJ) sdata_d = slot_bit(frame_d, cnt_d);
    else                sdata_d = slot_bit(frame_q, cnt_q);
  end

  always_ff @(negedge sclk_i) begin
    if (rst_i) begin
      cnt_q   <= '0;
      frame_q <= '0;
      last_q  <= '0;
      ws_q    <= 1'b0;
      sdata_q <= 1'b0;
      ur_q    <= 1'b0;
    end else begin
      cnt_q   <= cnt_d;
      frame_q <= frame_d;
      last_q  <= last_d;
      ws_q    <= ws_d;
      sdata_q <= sdata_d;
      ur_q    <= ur_d;
    end
  end

  assign ws_o       = ws_q;
  assign sdata_o    = sdata_q;
  assign underrun_o = ur_q;

endmodule

// File: tb/tb_i2s_tx_slot.sv
// tb_i2s_tx_slot: directed bench for i2s_tx_slot in three configurations
// (Philips 16/16 zero-fill, LJ 16/24, Philips 16/16 repeat). Outputs are
// sampled 1 ns after each falling edge; inputs are driven there as well.
module tb_i2s_tx_slot;
  import i2s_pkg::*;

  logic sclk = 1'b1;
  always #5 sclk = ~sclk;

  logic [15:0] left, right;
  logic        valid, mute;
  logic        rst_a, rst_b, rst_c;
  logic        rdy_a, ws_a, sd_a, ur_a;
  logic        rdy_b, ws_b, sd_b, ur_b;
  logic        rdy_c, ws_c, sd_c, ur_c;

  i2s_tx_slot #(.DATA_W(16), .SLOT_W(16), .MODE(I2S_PHILIPS), .UNDERRUN_REPEAT(1'b0)) u_a (
    .sclk_i(sclk), .rst_i(rst_a), .left_i(left), .right_i(right), .valid_i(valid),
    .ready_o(rdy_a), .mute_i(mute), .ws_o(ws_a), .sdata_o(sd_a), .underrun_o(ur_a));

  i2s_tx_slot #(.DATA_W(16), .SLOT_W(24), .MODE(I2S_LJ), .UNDERRUN_REPEAT(1'b0)) u_b (
    .sclk_i(sclk), .rst_i(rst_b), .left_i(left), .right_i(right), .valid_i(valid),
    .ready_o(rdy_b), .mute_i(mute), .ws_o(ws_b), .sdata_o(sd_b), .underrun_o(ur_b));

  i2s_tx_slot #(.DATA_W(16), .SLOT_W(16), .MODE(I2S_PHILIPS), .UNDERRUN_REPEAT(1'b1)) u_c (
    .sclk_i(sclk), .rst_i(rst_c), .left_i(left), .right_i(right), .valid_i(valid),
    .ready_o(rdy_c), .mute_i(mute), .ws_o(ws_c), .sdata_o(sd_c), .underrun_o(ur_c));

  int   sel;
  logic rdy, ws, sd, ur;
  always_comb begin
    rdy = rdy_a; ws = ws_a; sd = sd_a; ur = ur_a;
    case (sel)
      1: begin rdy = rdy_b; ws = ws_b; sd = sd_b; ur = ur_b; end
      2: begin rdy = rdy_c; ws = ws_c; sd = sd_c; ur = ur_c; end
      default: ;
    endcase
  end

  int checks   = 0;
  int failures = 0;
  int n_acc    = 0;
  int slot     = 16;
  bit lj       = 1'b0;
  bit inc_mode = 1'b0;

  task automatic chk1(input string tag, input logic obs, input logic exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s: observed=%b expected=%b", tag, obs, exp);
    end
  endtask

  task automatic chkn(input string tag, input int obs, input int exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // One falling edge. A pair offered while ready is counted as taken; in
  // increment mode the next pattern is presented, otherwise valid drops.
  task automatic tick();
    bit acc;
    acc = valid && rdy;
    @(negedge sclk);
    #1;
    if (acc) begin
      n_acc++;
      if (inc_mode) begin
        left  = left + 16'd1;
        right = right + 16'd1;
      end else begin
        valid = 1'b0;
      end
    end
  endtask

  // Left-justified schedule: position pos within a frame of slot width s.
  function automatic logic expbit(input logic [15:0] l, input logic [15:0] r,
                                  input int pos, input int s);
    int          i;
    logic [15:0] v;
    i = pos % s;
    v = (pos < s) ? l : r;
    return (i < 16) ? v[15 - i] : 1'b0;
  endfunction

  // Checks one whole frame starting at count 0; ends at count 0 of the next.
  // rdy_mode: 0 none, 1 ready only at load cycle, 2 ready at count 0 and load cycle.
  task automatic check_frame(input string tag, input logic [15:0] l, input logic [15:0] r,
                             input logic prev_lsb, input logic exp_ur, input int rdy_mode);
    for (int c = 0; c < 2 * slot; c++) begin
      logic e;
      if (lj) e = expbit(l, r, c, slot);
      else    e = (c == 0) ? prev_lsb : expbit(l, r, c - 1, slot);
      chk1($sformatf("%s ws c=%0d", tag, c), ws, c >= slot);
      chk1($sformatf("%s sdata c=%0d", tag, c), sd, e);
      chk1($sformatf("%s underrun c=%0d", tag, c), ur, (c == 0) ? exp_ur : 1'b0);
      if (rdy_mode == 1)
        chk1($sformatf("%s ready c=%0d", tag, c), rdy, c == 2 * slot - 1);
      else if (rdy_mode == 2)
        chk1($sformatf("%s ready c=%0d", tag, c), rdy, (c == 0) || (c == 2 * slot - 1));
      tick();
    end
  endtask

  initial begin
    sel = 0; left = '0; right = '0; valid = 1'b0; mute = 1'b0;
    rst_a = 1'b1; rst_b = 1'b1; rst_c = 1'b1;
    tick(); tick();
    chk1("reset ws", ws, 1'b0);
    chk1("reset sdata", sd, 1'b0);
    chk1("reset underrun", ur, 1'b0);
    chk1("reset ready", rdy, 1'b0);

    // ---- Philips 16/16, zero-fill on underrun
    rst_a = 1'b0; #1;
    chk1("A ready empty", rdy, 1'b1);
    check_frame("A f0", 16'h0000, 16'h0000, 1'b0, 1'b0, 0);
    left = 16'hA5F0; right = 16'h0F5A; valid = 1'b1;
    check_frame("A f1", 16'h0000, 16'h0000, 1'b0, 1'b1, 0);
    check_frame("A f2", 16'hA5F0, 16'h0F5A, 1'b0, 1'b0, 0);
    check_frame("A f3 starve", 16'h0000, 16'h0000, 1'b0, 1'b1, 0);
    left = 16'h1234; right = 16'h5678; valid = 1'b1; mute = 1'b1;
    check_frame("A f4", 16'h0000, 16'h0000, 1'b0, 1'b1, 0);
    mute = 1'b0;
    chk1("A mute consumed buffer", rdy, 1'b1);
    left = 16'h8001; right = 16'h7FFF; valid = 1'b1;
    check_frame("A f5 muted", 16'h0000, 16'h0000, 1'b0, 1'b0, 0);
    check_frame("A f6", 16'h8001, 16'h7FFF, 1'b0, 1'b0, 0);
    check_frame("A f7 starve", 16'h0000, 16'h0000, 1'b1, 1'b1, 0);

    // reset at count 20 with a pair buffered
    left = 16'hCAFE; right = 16'hBEEF; valid = 1'b1;
    repeat (20) tick();
    chk1("A c20 ws", ws, 1'b1);
    chk1("A c20 ready full", rdy, 1'b0);
    rst_a = 1'b1; #1;
    chk1("A ready in reset", rdy, 1'b0);
    tick();
    chk1("A rst ws", ws, 1'b0);
    chk1("A rst sdata", sd, 1'b0);
    chk1("A rst underrun", ur, 1'b0);
    chk1("A rst ready", rdy, 1'b0);
    rst_a = 1'b0; #1;
    check_frame("A post-rst f0", 16'h0000, 16'h0000, 1'b0, 1'b0, 0);
    check_frame("A post-rst f1", 16'h0000, 16'h0000, 1'b0, 1'b1, 0);

    // back-to-back stream, incrementing pattern
    left = 16'h0100; right = 16'h0200; valid = 1'b1; inc_mode = 1'b1; n_acc = 0;
    check_frame("A b2b f0", 16'h0000, 16'h0000, 1'b0, 1'b1, 2);
    for (int k = 1; k <= 8; k++)
      check_frame($sformatf("A b2b f%0d", k), 16'(16'h0100 + k - 1), 16'(16'h0200 + k - 1),
                  (k >= 2) ? 1'((k - 2) & 1) : 1'b0, 1'b0, 1);
    chkn("A b2b accepted", n_acc, 10);
    valid = 1'b0; inc_mode = 1'b0;

    // ---- LJ 16/24
    rst_a = 1'b1; sel = 1; slot = 24; lj = 1'b1;
    rst_b = 1'b0; #1;
    check_frame("B f0", 16'h0000, 16'h0000, 1'b0, 1'b0, 0);
    left = 16'hA5F0; right = 16'h0F5A; valid = 1'b1;
    check_frame("B f1", 16'h0000, 16'h0000, 1'b0, 1'b1, 0);
    check_frame("B f2", 16'hA5F0, 16'h0F5A, 1'b0, 1'b0, 0);
    check_frame("B f3 starve", 16'h0000, 16'h0000, 1'b0, 1'b1, 0);

    // ---- Philips 16/16, repeat on underrun
    rst_b = 1'b1; sel = 2; slot = 16; lj = 1'b0;
    rst_c = 1'b0; #1;
    check_frame("C f0", 16'h0000, 16'h0000, 1'b0, 1'b0, 0);
    left = 16'hA5F0; right = 16'h0F5A; valid = 1'b1;
    check_frame("C f1", 16'h0000, 16'h0000, 1'b0, 1'b1, 0);
    check_frame("C f2", 16'hA5F0, 16'h0F5A, 1'b0, 1'b0, 0);
    left = 16'h8001; right = 16'h7FFF; valid = 1'b1; mute = 1'b1;
    check_frame("C f3 repeat", 16'hA5F0, 16'h0F5A, 1'b0, 1'b1, 0);
    mute = 1'b0;
    check_frame("C f4 muted", 16'h0000, 16'h0000, 1'b0, 1'b0, 0);
    check_frame("C f5 repeat unmuted", 16'h8001, 16'h7FFF, 1'b0, 1'b1, 0);
    check_frame("C f6 repeat", 16'h8001, 16'h7FFF, 1'b1, 1'b1, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
